ahfp_sub_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational FP subtractor (ahfp_sub instance, outside this block) between NREQ requesters. Each accepted request has its operands registered, is held on the subtractor for a programmable settle time, and has its result captured and returned with the requester ID. It sits between the Nios custom-instruction wrappers and the single shared subtractor, so the subtractor's combinational path is not replicated per requester.

---
 rtl/ahfp_pkg.sv | 18 +
 rtl/ahfp_rr_pick.sv | 35 +++
 rtl/ahfp_sub_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ahfp_sub_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared definitions for the AHFP subtractor arbiter: FP width, FSM encoding,
// and canonical single-precision constants.
package ahfp_pkg;

  localparam int unsigned FP_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam logic [FP_W-1:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO     = 32'h4000_0000;
  localparam logic [FP_W-1:0] FP_THREE   = 32'h4040_0000;
  localparam logic [FP_W-1:0] FP_NEG_TWO = 32'hC000_0000;

endpackage

// File: rtl/ahfp_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr_i,
// wrapping modulo NREQ. Returns a one-hot grant and its encoded index.
module ahfp_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  int unsigned    pos;
  logic [IDW-1:0] pos_idx;
  logic           found;

  // Scan NREQ slots starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos     = (32'(rr_ptr_i) + k) % NREQ;
      pos_idx = IDW'(pos);
      if (!found && req_i[pos_idx]) begin
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahfp_sub_arbiter.sv
// Round-robin arbiter sharing one combinational FP subtractor between NREQ
// requesters. Operands are registered on accept, held LATENCY cycles, then
// the subtractor output is captured and returned with the requester ID.
// Optional statistics counters: define AHFP_SUB_ARB_STATS_EN.
module ahfp_sub_arbiter
  import ahfp_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [FP_W*NREQ-1:0] req_dataa,
  input  logic [FP_W*NREQ-1:0] req_datab,
  output logic [FP_W-1:0]      sub_dataa,
  output logic [FP_W-1:0]      sub_datab,
  input  logic [FP_W-1:0]      sub_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [FP_W-1:0]      result,
`ifdef AHFP_SUB_ARB_STATS_EN
  output logic [15:0]          op_count,
  output logic [15:0]          stall_count,
`endif
  output logic                 busy
);

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [FP_W-1:0] sub_a_q, sub_a_d;
  logic [FP_W-1:0] sub_b_q, sub_b_d;
  logic [FP_W-1:0] result_q, result_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            accept;

  ahfp_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req_i   (req_valid),
    .rr_ptr_i(rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == StIdle)) req_ready = pick_gnt;
  end

  assign accept = |(req_valid & req_ready);

  // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    sub_a_d      = sub_a_q;
    sub_b_d      = sub_b_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sub_a_d   = req_dataa[FP_W*pick_idx +: FP_W];
          sub_b_d   = req_datab[FP_W*pick_idx +: FP_W];
          resp_id_d = pick_idx;
          rr_ptr_d  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d     = CntLoad;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          result_d     = sub_result;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      sub_a_q      <= '0;
      sub_b_q      <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      sub_a_q      <= sub_a_d;
      sub_b_q      <= sub_b_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign sub_dataa  = sub_a_q;
  assign sub_datab  = sub_b_q;
  assign result     = result_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != StIdle);

`ifdef AHFP_SUB_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating counters for completed handshakes and blocked request cycles.
  always_comb begin
    op_count_d    = op_count_q;
    stall_count_d = stall_count_q;
    if (resp_valid_q && resp_ready && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
    if ((|req_valid) && !(|req_ready) && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      op_count_q    <= op_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ahfp_sub_arbiter.sv
// Self-checking bench for ahfp_sub_arbiter: directed steps plus randomized
// operations checked against a queue-free arithmetic reference of the grant
// order, latency and captured result. Stats checks need AHFP_SUB_ARB_STATS_EN.
module tb_ahfp_sub_arbiter;
  import ahfp_pkg::*;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       da [NREQ];
  logic [31:0]       db [NREQ];
  logic [32*NREQ-1:0] req_dataa, req_datab;
  logic [31:0]       sub_dataa, sub_datab, sub_result;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       result;
  logic              busy;
`ifdef AHFP_SUB_ARB_STATS_EN
  logic [15:0]       op_count, stall_count;
`endif

  always #5 clk = ~clk;

  assign req_dataa = {da[3], da[2], da[1], da[0]};
  assign req_datab = {db[3], db[2], db[1], db[0]};

  // Stand-in for the external subtractor: exact on the canonical constants,
  // an arbitrary but deterministic mix elsewhere.
  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_THREE && b == FP_ONE) return FP_TWO;
    if (a == FP_ONE && b == FP_THREE) return FP_NEG_TWO;
    return (a - b) ^ 32'h8000_0001;
  endfunction

  assign sub_result = fsub(sub_dataa, sub_datab);

  ahfp_sub_arbiter #(
    .NREQ   (NREQ),
    .IDW    (IDW),
    .LATENCY(LATENCY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dataa  (req_dataa),
    .req_datab  (req_datab),
    .sub_dataa  (sub_dataa),
    .sub_datab  (sub_datab),
    .sub_result (sub_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .result     (result),
`ifdef AHFP_SUB_ARB_STATS_EN
    .op_count   (op_count),
    .stall_count(stall_count),
`endif
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr      = 0;
  int last_acc = -1;
  int exp_ops  = 0;
  int exp_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // First valid requester at or after p, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic scramble;
    for (int i = 0; i < NREQ; i++) begin
      da[i] = $urandom;
      db[i] = $urandom;
    end
  endtask

  // One complete transaction: grant, latency, result, backpressure, release.
  task automatic run_op(input logic [NREQ-1:0] vmask, input int bp, input bit hold,
                        input bit cont);
    int g;
    int n;
    logic [31:0] exp_r;
    req_valid  = vmask;
    resp_ready = (bp == 0);
    #1;
    g     = model_pick(vmask, ptr);
    exp_r = fsub(da[g], db[g]);
    chk("grant", 32'(req_ready), 32'(1 << g));
    chk("busy_idle", 32'(busy), 32'd0);
    if (cont && last_acc >= 0) chk("spacing", 32'(cyc - last_acc), 32'(LATENCY + 2));
    last_acc = cyc;
    tick;
    ptr = (g + 1) % NREQ;
    if (!hold) req_valid = '0;
    scramble();
    #1;
    chk("ready_wait", 32'(req_ready), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    n = 0;
    while (!resp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", 32'(n), 32'(LATENCY));
    chk("result", result, exp_r);
    chk("resp_id", 32'(resp_id), 32'(g));
    if (hold) exp_stall += LATENCY + 1 + bp;
    for (int k = 0; k < bp; k++) begin
      tick;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_result", result, exp_r);
      chk("bp_id", 32'(resp_id), 32'(g));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick;
    exp_ops++;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic chk_stats;
`ifdef AHFP_SUB_ARB_STATS_EN
    chk("op_count", 32'(op_count), 32'(exp_ops > 65535 ? 65535 : exp_ops));
    chk("stall_count", 32'(stall_count), 32'(exp_stall > 65535 ? 65535 : exp_stall));
`endif
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      da[i] = '0;
      db[i] = '0;
    end
    tick;
    tick;
    reset_n = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_sub_a", sub_dataa, 32'd0);
    chk("rst_sub_b", sub_datab, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk_stats();

    // 3.0 - 1.0 from requester 2.
    da[2] = FP_THREE;
    db[2] = FP_ONE;
    run_op(4'b0100, 0, 1'b0, 1'b0);
    // Reversed operands from requester 0.
    da[0] = FP_ONE;
    db[0] = FP_THREE;
    run_op(4'b0001, 0, 1'b0, 1'b0);
    // Backpressure: five cycles of resp_ready low.
    run_op(4'b1000, 5, 1'b0, 1'b0);
    chk_stats();

    // Reset pulse while in WAIT discards the request.
    req_valid  = 4'b0010;
    resp_ready = 1'b1;
    #1;
    tick;
    req_valid = '0;
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n   = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("ready_in_rst", 32'(req_ready), 32'd0);
    tick;
    reset_n   = 1'b1;
    req_valid = '0;
    #1;
    ptr       = 0;
    exp_ops   = 0;
    exp_stall = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_id", 32'(resp_id), 32'd0);
    chk("mid_rst_sub_a", sub_dataa, 32'd0);
    chk("mid_rst_sub_b", sub_datab, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("no_resp", 32'(resp_valid), 32'd0);
    end
    chk_stats();

    // Fairness: all valid continuously, eight operations.
    last_acc = -1;
    for (int k = 0; k < 8; k++) run_op(4'hF, 0, 1'b1, 1'b1);
    chk_stats();

    // Randomized masks, operands, backpressure and holding.
    for (int k = 0; k < 24; k++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, 15));
      scramble();
      run_op(m, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end
    req_valid = '0;
    #1;
    chk_stats();

`ifdef AHFP_SUB_ARB_STATS_EN
    // Stall counter saturation: keep requests pending while held in RESP.
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    tick;
    for (int k = 0; k < 65600; k++) tick;
    chk("stall_sat", 32'(stall_count), 32'h0000_FFFF);
    resp_ready = 1'b1;
    req_valid  = '0;
    tick;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
